// File: rtl/cnt4_seg_display.sv
// Four-digit multiplexed common-anode display for a 4-bit counter: ones, tens, blank, direction letter.
// Optional blink of the whole display while stopped: define CNT4_SEG_DISPLAY_BLINK_EN.
module cnt4_seg_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] VAL,
  input  logic       MODE,
  input  logic       SS,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       CHG
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_digit_idx;
  logic [3:0]    r_val_q;
  logic [3:0]    r_val_prev;
  logic          r_mode_q;
  logic          r_ss_q;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_chg;

  logic          w_scan_wrap;
  logic          w_frame_done;
  logic          w_tens;
  logic [3:0]    w_ones;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;
  logic          w_an_off;

  function automatic logic [6:0] f_digit7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Input stage: plain one-cycle registration, no qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val_q  <= 4'd0;
      r_mode_q <= 1'b0;
      r_ss_q   <= 1'b0;
    end else begin
      r_val_q  <= VAL;
      r_mode_q <= MODE;
      r_ss_q   <= SS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val_prev <= 4'd0;
      r_chg      <= 1'b0;
    end else begin
      r_chg      <= (r_val_q != r_val_prev);
      r_val_prev <= r_val_q;
    end
  end

  assign w_scan_wrap  = (r_scan_cnt == SCAN_MAX);
  assign w_frame_done = w_scan_wrap && (r_digit_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
    end else if (w_scan_wrap) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_scan_cnt  <= r_scan_cnt + SW'(1);
    end
  end

`ifdef CNT4_SEG_DISPLAY_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_DIV - 1);

  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_ph;

  // Frames keep counting while running so the blink phase is continuous.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (w_frame_done) begin
      if (r_frame_cnt == FRAME_MAX) begin
        r_frame_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  assign w_an_off = ~r_ss_q & r_blink_ph;
`else
  localparam int W_UNUSED_BLINK_DIV = BLINK_DIV;
  logic w_unused_sig;
  assign w_unused_sig = r_ss_q ^ w_frame_done;
  assign w_an_off     = 1'b0;
`endif

  assign w_tens = (r_val_q >= 4'd10);
  assign w_ones = r_val_q - (w_tens ? 4'd10 : 4'd0);

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    case (r_digit_idx)
      2'd0:    w_seg_nxt = f_digit7(w_ones);
      2'd1:    w_seg_nxt = w_tens ? f_digit7(4'd1) : SEG_BLANK;
      2'd2:    w_seg_nxt = SEG_BLANK;
      default: w_seg_nxt = r_mode_q ? SEG_U : SEG_D;
    endcase
  end

  assign w_an_nxt = w_an_off ? 4'b1111 : ~(4'b0001 << r_digit_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign SEG = r_seg;
  assign AN  = r_an;
  assign CHG = r_chg;

endmodule

// File: tb/tb_cnt4_seg_display.sv
// Bench for cnt4_seg_display: per-cycle model comparison plus directed literal checks.
module tb_cnt4_seg_display;

  localparam int SD = 4;
  localparam int BD = 2;
  localparam int HMAX = 4096;

  localparam logic [6:0] DIG7 [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};
  localparam logic [6:0] S_U  = 7'b1000001;
  localparam logic [6:0] S_D  = 7'b0100001;
  localparam logic [6:0] S_BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] VAL;
  logic       MODE;
  logic       SS;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic       CHG;

  int n_cmp = 0;
  int n_bad = 0;

  // Input history, one entry per rising edge; h_k = non-reset edges since last reset.
  logic h_rst [0:HMAX-1];
  int   h_val [0:HMAX-1];
  int   h_mode[0:HMAX-1];
  int   h_ss  [0:HMAX-1];
  int   h_k   [0:HMAX-1];
  int   n_edges = 0;

  cnt4_seg_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .VAL(VAL), .MODE(MODE), .SS(SS),
    .SEG(SEG), .AN(AN), .CHG(CHG)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (n_edges < HMAX) begin
      h_rst[n_edges]  = rst;
      h_val[n_edges]  = int'(VAL);
      h_mode[n_edges] = int'(MODE);
      h_ss[n_edges]   = int'(SS);
      h_k[n_edges]    = rst ? 0 : ((n_edges == 0) ? 1 : h_k[n_edges-1] + 1);
      n_edges++;
    end
  end

  // Registered input values as seen by the logic just before edge m.
  function automatic int vq_at(int m);
    if (m < 1) return 0;
    return h_rst[m-1] ? 0 : h_val[m-1];
  endfunction
  function automatic int mq_at(int m);
    if (m < 1) return 0;
    return h_rst[m-1] ? 0 : h_mode[m-1];
  endfunction
  function automatic int sq_at(int m);
    if (m < 1) return 0;
    return h_rst[m-1] ? 0 : h_ss[m-1];
  endfunction

  function automatic logic [6:0] exp_seg(int pos, int v, int m);
    case (pos)
      0:       return DIG7[v % 10];
      1:       return (v >= 10) ? DIG7[1] : S_BL;
      2:       return S_BL;
      default: return (m != 0) ? S_U : S_D;
    endcase
  endfunction

  always @(negedge clk) begin
    if (n_edges > 0 && n_edges <= HMAX) begin
      automatic int n = n_edges - 1;
      automatic logic [3:0] e_an;
      automatic logic [6:0] e_seg;
      automatic logic       e_chg;
      if (h_rst[n]) begin
        e_an = 4'b1111; e_seg = S_BL; e_chg = 1'b0;
      end else begin
        automatic int j   = h_k[n] - 1;
        automatic int pos = (j / SD) % 4;
        automatic int v   = vq_at(n);
        e_seg = exp_seg(pos, v, mq_at(n));
        e_an  = ~(4'b0001 << pos);
`ifdef CNT4_SEG_DISPLAY_BLINK_EN
        if (sq_at(n) == 0 && ((j / (4 * SD)) / BD) % 2 == 1) e_an = 4'b1111;
`endif
        e_chg = h_rst[n-1] ? 1'b0 : (vq_at(n) != vq_at(n-1));
      end
      chk("model_AN", AN, e_an);
      chk("model_SEG", SEG, e_seg);
      chk("model_CHG", CHG, e_chg);
    end
  end

  task automatic wait_an(input logic [3:0] a, input string nm);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (AN == a) break;
    end
    chk(nm, AN, a);
  endtask

  initial begin
    automatic int cnt;
    rst = 1'b1; VAL = 4'd0; MODE = 1'b1; SS = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // One full frame after reset: '0', blank, blank, 'U'.
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      case ((c - 1) / 4)
        0: begin chk("rst_frame_an0", AN, 4'b1110); chk("rst_frame_seg0", SEG, 7'b1000000); end
        1: begin chk("rst_frame_an1", AN, 4'b1101); chk("rst_frame_seg1", SEG, 7'b1111111); end
        2: begin chk("rst_frame_an2", AN, 4'b1011); chk("rst_frame_seg2", SEG, 7'b1111111); end
        default: begin chk("rst_frame_an3", AN, 4'b0111); chk("rst_frame_seg3", SEG, 7'b1000001); end
      endcase
      chk("rst_frame_chg", CHG, 1'b0);
    end

    VAL = 4'd7;
    repeat (20) @(negedge clk);
    VAL = 4'd12;
    @(negedge clk); chk("chg12_t1", CHG, 1'b0);
    @(negedge clk); chk("chg12_t2", CHG, 1'b1);
    @(negedge clk); chk("chg12_t3", CHG, 1'b0);
    wait_an(4'b1110, "wait_d0_12"); chk("seg12_ones", SEG, 7'b0100100);
    wait_an(4'b1101, "wait_d1_12"); chk("seg12_tens", SEG, 7'b1111001);

    // Sweep 0..15 then wrap to 0, one change per frame.
    for (int v = 0; v <= 16; v++) begin
      VAL = 4'(v % 16);
      @(negedge clk);
      @(negedge clk); chk("sweep_chg", CHG, 1'b1);
      repeat (14) @(negedge clk);
    end

    wait_an(4'b1011, "wait_d2_mode");
    wait_an(4'b0111, "wait_d3_mode");
    MODE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mode_seg_d", SEG, 7'b0100001);
    chk("mode_an", AN, 4'b0111);
    chk("mode_chg", CHG, 1'b0);

    wait_an(4'b1011, "wait_d2_rst");
    rst = 1'b1; VAL = 4'd0;
    @(negedge clk);
    chk("midrst_an", AN, 4'b1111); chk("midrst_seg", SEG, 7'b1111111);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_an", AN, 4'b1110); chk("postrst_seg", SEG, 7'b1000000);

    SS = 1'b0;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (AN == 4'b1111) cnt++;
    end
`ifdef CNT4_SEG_DISPLAY_BLINK_EN
    chk("stopped_off_cycles", cnt, 32);
`else
    chk("stopped_off_cycles", cnt, 0);
`endif

    SS = 1'b1;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (AN == 4'b1111) cnt++;
    end
    chk("running_off_cycles", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
